pipelined_flag_adder: RTL

//  Parametrised N-bit add/subtract unit for the ALU datapath; successor to the combinational N-bit adder.

---
 rtl/pipelined_flag_adder_pkg.sv | 12 +
 rtl/adder_slice.sv | 16 +
 rtl/pipelined_flag_adder.sv | 122 ++++++++++++
 3 files changed

// File: rtl/pipelined_flag_adder_pkg.sv
// pipelined_flag_adder_pkg: shared op encodings for the pipelined add/subtract unit.
//   OP_W : width of the op field
//   op_e : OP_ADD (a+b), OP_ADC (a+b+cin), OP_SUB (a-b), OP_SBC (a-b-1+cin)
package pipelined_flag_adder_pkg;
    localparam int OP_W = 2;
    typedef enum logic [OP_W-1:0] {
        OP_ADD = 2'b00,
        OP_ADC = 2'b01,
        OP_SUB = 2'b10,
        OP_SBC = 2'b11
    } op_e;
endpackage

// File: rtl/adder_slice.sv
// adder_slice: combinational W-bit adder slice, {co, sum} = a + b + ci.
//   a, b : W-bit slice operands (b already conditionally inverted by the caller)
//   ci   : carry in from the previous slice
//   sum  : W-bit slice sum
//   co   : carry out of the slice MSB
module adder_slice #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] sum,
    output logic         co
);
    assign {co, sum} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
endmodule

// File: rtl/pipelined_flag_adder.sv
// pipelined_flag_adder: N-bit ADD/ADC/SUB/SBC with NZCV flags, carry chain split over STAGES registered slices.
//   clk, rst             : clock (rising edge), asynchronous active-high reset
//   in_valid / in_ready  : input handshake; in_ready drops only while the output is stalled
//   a, b, op, cin        : operands, operation (see pipelined_flag_adder_pkg), carry in for ADC/SBC
//   out_valid / out_ready: output handshake
//   result               : a + b' + c0 modulo 2^N
//   flag_n/z/c/v         : negative, zero, carry out (SUB: 1 = no borrow), signed overflow
module pipelined_flag_adder
    import pipelined_flag_adder_pkg::*;
#(
    parameter int N      = 32,
    parameter int STAGES = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [N-1:0]    a,
    input  logic [N-1:0]    b,
    input  logic [OP_W-1:0] op,
    input  logic            cin,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [N-1:0]    result,
    output logic            flag_n,
    output logic            flag_z,
    output logic            flag_c,
    output logic            flag_v
);
    localparam int W = N / STAGES;

    logic         stall;
    logic [N-1:0] bp;
    logic         c0;

    // The whole pipe freezes as one unit; bubbles are never squeezed out.
    assign stall    = out_valid & ~out_ready;
    assign in_ready = ~stall;
    assign bp       = op[1] ? ~b : b;
    assign c0       = (op == OP_ADD) ? 1'b0 : (op == OP_SUB) ? 1'b1 : cin;

    genvar k;
    for (k = 0; k < STAGES; k++) begin : g
        // Operand bits still to be summed when entering stage k.
        localparam int UI = N - k * W;
        logic [UI-1:0]        ai, bi;
        logic                 ci, vi, co, v;
        logic [W-1:0]         s;
        logic [(k+1)*W-1:0]   rn, r;

        if (k == 0) begin : src
            assign ai = a;
            assign bi = bp;
            assign ci = c0;
            assign vi = in_valid;
            assign rn = s;
        end else begin : src
            assign ai = g[k-1].fwd.ua;
            assign bi = g[k-1].fwd.ub;
            assign ci = g[k-1].fwd.c;
            assign vi = g[k-1].v;
            assign rn = {s, g[k-1].r};
        end

        adder_slice #(.W(W)) u_slice (
            .a  (ai[W-1:0]),
            .b  (bi[W-1:0]),
            .ci (ci),
            .sum(s),
            .co (co)
        );

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v <= 1'b0;
                r <= '0;
            end else if (!stall) begin
                v <= vi;
                r <= rn;
            end
        end

        if (k < STAGES - 1) begin : fwd
            // Skewed operand storage: only the bits later slices still need.
            logic [UI-W-1:0] ua, ub;
            logic            c;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    c  <= 1'b0;
                    ua <= '0;
                    ub <= '0;
                end else if (!stall) begin
                    c  <= co;
                    ua <= ai[UI-1:W];
                    ub <= bi[UI-1:W];
                end
            end
        end else begin : fin
            logic fn, fz, fc, fv;
            // ai/bi MSBs here are a[N-1] and b'[N-1] of the operation in this stage.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    fn <= 1'b0;
                    fz <= 1'b0;
                    fc <= 1'b0;
                    fv <= 1'b0;
                end else if (!stall) begin
                    fn <= rn[N-1];
                    fz <= ~|rn;
                    fc <= co;
                    fv <= (ai[UI-1] == bi[UI-1]) & (rn[N-1] != ai[UI-1]);
                end
            end
            assign out_valid = v;
            assign result    = r;
            assign flag_n    = fn;
            assign flag_z    = fz;
            assign flag_c    = fc;
            assign flag_v    = fv;
        end
    end
endmodule
